// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented two's-complement adder/subtractor with
// valid/ready handshakes. One SEG_W-bit segment is added per stage and the
// segment carry is registered between stages; throughput is one beat/cycle.
//
// Parameters: WIDTH (operand width, multiple of SEG_W), SEG_W (bits per stage).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready depends on out_ready)
//   A, B, Sub, Cin        operands; Sub=1 computes A-B and ignores Cin
//   out_valid / out_ready result handshake
//   S, Cout, Ovf          registered result, carry out, signed overflow
// Optional feature: define PIPELINED_ADDSUB_SAT_EN for signed saturation of S.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NSEG = WIDTH / SEG_W;
  localparam int unsigned LAST = NSEG - 1;

  logic [NSEG-1:0]  valid_q, valid_d;
  logic [NSEG-1:0]  c_q, c_d;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] s_d [NSEG];
  logic             ovf_q, ovf_d;

  // Per-stage inputs: stage 0 takes the port operands, stage k the stage k-1 register.
  logic [WIDTH-1:0] a_src [NSEG];
  logic [WIDTH-1:0] b_src [NSEG];
  logic [WIDTH-1:0] s_src [NSEG];
  logic [NSEG-1:0]  c_src;
  logic [NSEG-1:0]  v_src;
  logic [NSEG:0]    acc;

  // Stage input selection; B is inverted and carry-in forced to 1 for subtraction.
  always_comb begin
    c_src    = '0;
    v_src    = '0;
    a_src[0] = A;
    b_src[0] = B ^ {WIDTH{Sub}};
    s_src[0] = '0;
    c_src[0] = Sub | Cin;
    v_src[0] = in_valid;
    for (int k = 1; k < int'(NSEG); k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = valid_q[k-1];
    end
  end

  // Accept chain from the output backwards: a stage accepts when empty or draining.
  always_comb begin
    logic [NSEG:0] chain;
    chain       = '0;
    chain[NSEG] = out_ready;
    for (int k = int'(NSEG) - 1; k >= 0; k--) begin
      chain[k] = !valid_q[k] || chain[k+1];
    end
    acc = chain;
  end

  // Stage next-state: add segment k of the incoming beat when the stage accepts.
  always_comb begin
    logic [SEG_W:0]   seg_sum;
    logic [WIDTH-1:0] s_new;
    logic             ovf_w;
    valid_d = valid_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    seg_sum = '0;
    s_new   = '0;
    ovf_w   = 1'b0;
    for (int k = 0; k < int'(NSEG); k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
    for (int k = 0; k < int'(NSEG); k++) begin
      seg_sum = {1'b0, a_src[k][k*SEG_W +: SEG_W]} + {1'b0, b_src[k][k*SEG_W +: SEG_W]}
              + (SEG_W+1)'(c_src[k]);
      s_new = s_src[k];
      s_new[k*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
      if (acc[k]) begin
        valid_d[k] = v_src[k];
        if (v_src[k]) begin
          a_d[k] = a_src[k];
          b_d[k] = b_src[k];
          c_d[k] = seg_sum[SEG_W];
          s_d[k] = s_new;
          if (k == int'(LAST)) begin
            // Overflow: operand signs agree (after inversion) but result sign differs.
            ovf_w = (a_src[k][WIDTH-1] == b_src[k][WIDTH-1]) &&
                    (s_new[WIDTH-1] != a_src[k][WIDTH-1]);
            ovf_d = ovf_w;
`ifdef PIPELINED_ADDSUB_SAT_EN
            if (ovf_w) begin
              s_d[k] = a_src[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
          end
        end
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < int'(NSEG); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < int'(NSEG); k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign in_ready  = acc[0];
  assign out_valid = valid_q[LAST];
  assign S         = s_q[LAST];
  assign Cout      = c_q[LAST];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub (WIDTH=32, SEG_W=8): directed corner cases,
// streaming/backpressure, asynchronous reset and a randomised run, all checked
// by an in-order scoreboard against an integer-arithmetic reference model.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] A, B;
  logic        Sub, Cin;
  logic        out_valid, out_ready;
  logic [31:0] S;
  logic        Cout, Ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   in_cnt = 0;
  exp_t exp_cur;
  exp_t exp_q[$];
  int   out_cyc_q[$];
  exp_t e_pop;
  logic        hold = 1'b0;
  logic [31:0] held_s;
  logic        held_c, held_o;
  logic        rand_done;

  pipelined_addsub #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sub(Sub), .Cin(Cin), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then wrap / saturate to 32 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    exp_t r;
    longint sa, sb, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (sub) begin
      sr  = sa - sb;
      r.c = (ua >= ub);
    end else begin
      sr  = sa + sb + longint'(cin);
      r.c = ((ua + ub + longint'(cin)) >= 64'h1_0000_0000);
    end
    r.s = sr[31:0];
    r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (r.o) r.s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return r;
  endfunction

  // Monitor/scoreboard: transfers are decided by the values visible at negedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_S", 64'(S), 64'(held_s));
        chk("hold_Cout", 64'(Cout), 64'(held_c));
        chk("hold_Ovf", 64'(Ovf), 64'(held_o));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_cur);
        in_cnt++;
      end
      if (out_valid && out_ready) begin
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got S=%0h expected no output", S);
        end else begin
          e_pop = exp_q.pop_front();
          chk("S", 64'(S), 64'(e_pop.s));
          chk("Cout", 64'(Cout), 64'(e_pop.c));
          chk("Ovf", 64'(Ovf), 64'(e_pop.o));
        end
      end
      hold   = out_valid && !out_ready;
      held_s = S;
      held_c = Cout;
      held_o = Ovf;
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin, input exp_t e);
    logic fired;
    fired    = 1'b0;
    in_valid = 1'b1;
    A = a; B = b; Sub = sub; Cin = cin;
    exp_cur = e;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!fired) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance of A=%0h", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_beat();
    logic [31:0] a, b;
    logic        sub, cin;
    a   = $urandom();
    b   = $urandom();
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
    if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
    drive(a, b, sub, cin, model(a, b, sub, cin));
  endtask

  initial begin
    int lat;
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Sub = 1'b0; Cin = 1'b0;
    exp_cur = '0;
    rand_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_S", 64'(S), 64'd0);
    chk("rst_Cout", 64'(Cout), 64'd0);
    chk("rst_Ovf", 64'(Ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cross-segment carry and latency.
    out_ready = 1'b1;
    e.s = 32'h0000_0000; e.c = 1'b1; e.o = 1'b0;
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    chk("latency", 64'(lat), 64'd4);
    drain();

    // Signed overflow and subtraction corner cases.
`ifdef PIPELINED_ADDSUB_SAT_EN
    e.s = 32'h7FFF_FFFF;
`else
    e.s = 32'h8000_0000;
`endif
    e.c = 1'b0; e.o = 1'b1;
    drive(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, e);
    e.s = 32'hFFFF_FFFE; e.c = 1'b0; e.o = 1'b0;
    drive(32'd5, 32'd7, 1'b1, 1'b1, e);
`ifdef PIPELINED_ADDSUB_SAT_EN
    e.s = 32'h8000_0000;
`else
    e.s = 32'h7FFF_FFFF;
`endif
    e.c = 1'b1; e.o = 1'b1;
    drive(32'h8000_0000, 32'h1, 1'b1, 1'b0, e);
    drain();

    // Eight back-to-back beats must emerge on consecutive cycles.
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) rand_beat();
    drain();
    chk("stream_count", 64'(out_cyc_q.size()), 64'd8);
    if (out_cyc_q.size() == 8)
      chk("stream_span", 64'(out_cyc_q[7] - out_cyc_q[0]), 64'd7);

    // Backpressure: the pipeline holds exactly four beats.
    out_ready = 1'b0;
    in_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) rand_beat();
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(in_cnt), 64'd4);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total", 64'(in_cnt), 64'd6);

    // Asynchronous reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) rand_beat();
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_S", 64'(S), 64'd0);
    chk("arst_Cout", 64'(Cout), 64'd0);
    chk("arst_Ovf", 64'(Ovf), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    out_cyc_q.delete();
    e.s = 32'd7; e.c = 1'b0; e.o = 1'b0;
    drive(32'd3, 32'd4, 1'b0, 1'b0, e);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    chk("post_rst_latency", 64'(lat), 64'd4);
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_outputs", 64'(out_cyc_q.size()), 64'd1);

    // Randomised traffic with random idles and backpressure.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          rand_beat();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
